// File: rtl/clock_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even divisors.
// Divisor and enable changes are applied only at output period boundaries.
module clock_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 33
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_err,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             running_q, running_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             tick_q, tick_d;
  logic             div_err_q, div_err_d;
  logic             boundary;
  logic [WIDTH-1:0] half_next;

  assign boundary = !running_q || (cnt_q == active_q - ONE);

  // Divisors below 2 cannot produce a clock, so they are rejected and flagged.
  always_comb begin
    pending_d = pending_q;
    div_err_d = 1'b0;
    if (div_load) begin
      if (div_val >= TWO) begin
        pending_d = div_val;
      end else begin
        div_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    running_d = running_q;
    pos_d     = pos_q;
    tick_d    = 1'b0;
    half_next = active_q >> 1;
    if (boundary) begin
      if (en) begin
        active_d  = pending_q;
        cnt_d     = '0;
        running_d = 1'b1;
        tick_d    = 1'b1;
        half_next = pending_q >> 1;
        pos_d     = (cnt_d < half_next);
      end else begin
        running_d = 1'b0;
        cnt_d     = '0;
        pos_d     = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + ONE;
      pos_d = (cnt_d < half_next);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      active_q  <= DIV_RST;
      pending_q <= DIV_RST;
      running_q <= 1'b0;
      pos_q     <= 1'b0;
      tick_q    <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      running_q <= running_d;
      pos_q     <= pos_d;
      tick_q    <= tick_d;
      div_err_q <= div_err_d;
    end
  end

  // Half-cycle delayed copy stretches the high phase by half a cycle for odd divisors.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out    = active_q[0] ? (pos_q | neg_q) : pos_q;
  assign tick       = tick_q;
  assign div_err    = div_err_q;
  assign div_active = active_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: half-cycle waveform model, vector table,
// directed corner sequences and randomized divisor/enable traffic.
`timescale 1ns/1ps
module tb_clock_div_prog;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         clk_out;
  logic         tick;
  logic         div_err;
  logic [W-1:0] div_active;

  int checks = 0;
  int failures = 0;

  // Expected output per half clk_in cycle; a period of N pushes N high and N low halves.
  typedef struct packed {
    logic lvl;
    logic tk;
  } half_t;
  half_t exp_q[$];
  logic [W-1:0] m_pending = W'(33);
  logic [W-1:0] m_active  = W'(33);
  logic         m_err     = 1'b0;

  typedef struct packed {
    logic         ld;
    logic [W-1:0] val;
    logic         exp_err;
  } vec_t;
  vec_t vecs[6];

  time  last_rise = 0, last_fall = 0, last_period = 0, last_high = 0;
  int   ticks;
  logic found;

  clock_div_prog #(.WIDTH(W), .DEFAULT_DIV(33)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_val   (div_val),
    .div_load  (div_load),
    .clk_out   (clk_out),
    .tick      (tick),
    .div_err   (div_err),
    .div_active(div_active)
  );

  always #100 clk_in = ~clk_in;

  always @(posedge clk_out) begin
    if (last_rise != 0) last_period = $time - last_rise;
    last_rise = $time;
  end
  always @(negedge clk_out) begin
    last_fall = $time;
    last_high = $time - last_rise;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    if (exp_q.size() == 0) begin
      if (en) begin
        m_active = m_pending;
        for (int i = 0; i < 2 * int'(m_active); i++)
          exp_q.push_back(half_t'{lvl: (i < int'(m_active)), tk: (i < 2)});
      end else begin
        exp_q.push_back(half_t'{lvl: 1'b0, tk: 1'b0});
        exp_q.push_back(half_t'{lvl: 1'b0, tk: 1'b0});
      end
    end
    m_err = div_load && (div_val < W'(2));
    if (div_load && (div_val >= W'(2))) m_pending = div_val;
  endtask

  task automatic check_half(input string tag);
    half_t e;
    if (exp_q.size() == 0) e = half_t'{lvl: 1'b0, tk: 1'b0};
    else e = exp_q.pop_front();
    chk({tag, "_clk_out"}, 32'(clk_out), 32'(e.lvl));
    chk({tag, "_tick"}, 32'(tick), 32'(e.tk));
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    #1;
    check_half("pos");
    chk("div_err", 32'(div_err), 32'(m_err));
    chk("div_active", 32'(div_active), 32'(m_active));
    @(negedge clk_in);
    #1;
    check_half("neg");
  endtask

  task automatic chk_shape(input string name, input int per, input int hi);
    chk({name, "_period"}, 32'(last_period), 32'(per));
    chk({name, "_high"}, 32'(last_high), 32'(hi));
    chk({name, "_rise_on_posedge"}, 32'(last_rise % 200), 32'd100);
  endtask

  initial begin
    vecs[0] = '{ld: 1'b1, val: W'(0),   exp_err: 1'b1};
    vecs[1] = '{ld: 1'b1, val: W'(1),   exp_err: 1'b1};
    vecs[2] = '{ld: 1'b1, val: W'(2),   exp_err: 1'b0};
    vecs[3] = '{ld: 1'b1, val: W'(255), exp_err: 1'b0};
    vecs[4] = '{ld: 1'b1, val: W'(33),  exp_err: 1'b0};
    vecs[5] = '{ld: 1'b0, val: W'(1),   exp_err: 1'b0};

    // Reset state
    #250;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_div_err", 32'(div_err), 32'd0);
    chk("rst_div_active", 32'(div_active), 32'd33);
    @(negedge clk_in);
    #10 rst = 1'b1;

    // Load vectors while idle
    for (int i = 0; i < 6; i++) begin
      div_load = vecs[i].ld;
      div_val  = vecs[i].val;
      cycle();
      chk("tbl_div_err", 32'(div_err), 32'(vecs[i].exp_err));
    end
    div_load = 1'b0;

    // Default divide-by-33
    en = 1'b1;
    repeat (70) cycle();
    chk_shape("n33", 6600, 3300);
    chk("n33_fall_on_negedge", 32'(last_fall % 200), 32'd0);

    // Mid-period load of 4
    div_load = 1'b1; div_val = W'(4);
    cycle();
    div_load = 1'b0;
    chk("n4_not_yet", 32'(div_active), 32'd33);
    repeat (40) cycle();
    chk_shape("n4", 800, 400);

    // Load 5 on the boundary cycle of an N=4 period
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (exp_q.size() == 0) found = 1'b1;
      else cycle();
    end
    chk("sync_boundary", 32'(found), 32'd1);
    div_load = 1'b1; div_val = W'(5);
    cycle();
    div_load = 1'b0;
    chk("n5_one_more_4", 32'(div_active), 32'd4);
    repeat (24) cycle();
    chk_shape("n5", 1000, 500);
    chk("n5_fall_on_negedge", 32'(last_fall % 200), 32'd0);

    // Rejected loads
    div_load = 1'b1; div_val = W'(1);
    cycle();
    chk("err_val1", 32'(div_err), 32'd1);
    div_val = W'(0);
    cycle();
    chk("err_val0", 32'(div_err), 32'd1);
    div_load = 1'b0;
    repeat (12) cycle();
    chk("err_keeps_n5", 32'(div_active), 32'd5);
    chk_shape("err_n5", 1000, 500);

    // Drop en while high at N=6
    div_load = 1'b1; div_val = W'(6);
    cycle();
    div_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (div_active == W'(6) && clk_out) found = 1'b1;
    end
    chk("n6_high_found", 32'(found), 32'd1);
    en = 1'b0;
    repeat (12) cycle();
    chk("en_off_low", 32'(clk_out), 32'd0);
    ticks = 0;
    repeat (8) begin
      cycle();
      if (tick) ticks++;
    end
    chk("en_off_no_tick", 32'(ticks), 32'd0);
    en = 1'b1;
    cycle();
    chk("en_on_rise", 32'(clk_out), 32'd1);

    // Asynchronous reset in the high phase at N=7
    div_load = 1'b1; div_val = W'(7);
    cycle();
    div_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (div_active == W'(7) && clk_out) found = 1'b1;
    end
    chk("n7_high_found", 32'(found), 32'd1);
    @(posedge clk_in);
    #40;
    chk("pre_rst_high", 32'(clk_out), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_clk_out", 32'(clk_out), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    chk("async_rst_div_active", 32'(div_active), 32'd33);
    @(negedge clk_in);
    #1;
    chk("rst_hold_clk_out", 32'(clk_out), 32'd0);
    #10 rst = 1'b1;
    exp_q.delete();
    m_pending = W'(33);
    m_active  = W'(33);
    repeat (70) cycle();
    chk_shape("post_rst", 6600, 3300);

    // Randomized enable and divisor traffic
    repeat (500) begin
      en       = ($urandom % 8) != 0;
      div_load = ($urandom % 6) == 0;
      div_val  = (($urandom % 4) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(2, 24));
      cycle();
    end
    en = 1'b0;
    div_load = 1'b0;
    repeat (60) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_div_prog.md
Name: clock_div_prog

Overview:
- Runtime-programmable integer clock divider producing a 50%-duty output for any divisor, odd or even, in the range 2..2^WIDTH-1.
- Generalises the fixed divide-by-33 block. Adds a parametrised width, a loadable divisor, a run enable, a period-start tick and illegal-value flagging.
- Divisor and enable changes take effect only at period boundaries, so clk_out never glitches.
- Sits between the board clock and downstream slow-clock consumers.

Parameters:
- WIDTH, 8, width of the divisor and internal counter.
- DEFAULT_DIV, 33, divisor loaded at reset. Must be 2..2^WIDTH-1.

Ports:
- clk_in  input  1  source clock; all state on posedge except neg_q.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  run request; sampled at period boundaries.
- div_val  input  WIDTH  requested divisor N.
- div_load  input  1  single-cycle strobe capturing div_val into pending.
- clk_out  output  1  divided clock, 50% duty.
- tick  output  1  one-clk_in-cycle pulse at the start of each output period.
- div_err  output  1  one-cycle pulse when a rejected value is loaded.
- div_active  output  WIDTH  divisor currently in effect.

Behaviour:
- Registers: cnt[WIDTH], active[WIDTH], pending[WIDTH], odd (= active[0]), running, pos_q (posedge), neg_q (negedge), tick, div_err.
- Reset (rst=0, asynchronous): cnt=0, running=0, pos_q=0, neg_q=0, tick=0, div_err=0, active=pending=DEFAULT_DIV. Hence clk_out=0 and div_active=DEFAULT_DIV.
  - Applies mid-operation too: clk_out drops immediately, with no completion of the current period.
- Let H = floor(active/2).
- Load:
  - On a posedge with div_load=1 and div_val>=2: pending <= div_val.
  - On a posedge with div_load=1 and div_val<2: pending unchanged, div_err=1 for exactly one cycle. Otherwise div_err=0.
- Boundary (B): a posedge where !running, or where running && cnt==active-1.
- At B with en=1:
  - active <= pending, as registered before this edge. A load in the same cycle applies at the next B.
  - cnt <= 0, running <= 1.
- At B with en=0: running <= 0, cnt <= 0, pos_q <= 0. The output holds low.
- Non-boundary running posedge: cnt <= cnt+1. en and pending are ignored until the next B.
- pos_q: on each running posedge, pos_q <= (cnt_next < H_next), where H_next uses the active value in effect after this edge.
  - Result: pos_q is high for H clk_in cycles starting at the posedge where cnt becomes 0.
- neg_q: on each negedge clk_in, neg_q <= pos_q. Also reset asynchronously.
- clk_out = odd ? (pos_q | neg_q) : pos_q.
  - Odd N: high H+0.5 cycles, low H+0.5 cycles.
  - Even N: high N/2, low N/2 cycles.
  - The output must be a single gate with registered inputs.
- tick: registered, high for the one cycle in which cnt==0 and running==1 following a B with en=1. Aligned with the rising edge of clk_out.
- Start latency: with rst released and en=1, the first posedge is a B. clk_out rises at that posedge (pos_q=1 when H>=1).
- Divisor change: output period k uses the active value latched at its starting B. There are no truncated or stretched periods.
- en deassert mid-period: the current period completes in full, then clk_out stays 0. Re-assert restarts at the next posedge.
- Wrap: cnt never exceeds active-1. Since active<=2^WIDTH-1, cnt never overflows.

Test Plan:
- Reset, then en=1 with default N=33, clk_in period 200 ns:
  - clk_out period 6600 ns, high exactly 3300 ns, edges alternating on posedge/negedge.
  - tick is one 200 ns pulse per 6600 ns.
  - div_active=33.
- div_val=4 with div_load pulsed mid-period at N=33:
  - Current 33-cycle period completes untouched.
  - Next periods are 4 cycles with 2 high / 2 low.
  - div_active changes to 4 exactly at that boundary.
- div_val=5 loaded on the same cycle as a boundary at N=4:
  - One more 4-cycle period runs.
  - Then 5-cycle periods with high 2.5 cycles / low 2.5 cycles.
- div_val=1, then div_val=0 loaded:
  - div_err pulses one cycle each.
  - pending and active are unchanged; period unaffected.
- en dropped while clk_out is high (N=6):
  - Period finishes (3 high, 3 low).
  - clk_out then stays 0 with no tick.
  - en=1 again: clk_out rises on the next posedge.
- rst asserted low mid-high phase (N=7):
  - clk_out, tick and neg_q go 0 asynchronously.
  - After release, div_active=33 and a full-length first period follows.
